lz77_decoder: RTL and testbench

LZ77_DECODER -- requirements
Module: lz77_decoder

---
 rtl/lz77_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_lz77_decoder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_decoder.sv
// LZ77 token stream decoder: literals, end-of-block and (code, length, distance) back-references into a byte history.
// Latency: one cycle from token acceptance to the decoded byte; copies run at one byte per cycle.
// Backpressure: a stalled output register stalls the copy engine and tok_ready; illegal sequences lock into ERR until rst/clr.
module lz77_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int TOKEN_WIDTH = 16,
    parameter int HIST_SIZE   = 64,
    parameter int MAX_LENGTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   tok_valid,
    input  logic [TOKEN_WIDTH-1:0] tok_data,
    output logic                   tok_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_ready,
    output logic                   done,
    output logic                   error
);

    localparam int HIST_AW = $clog2(HIST_SIZE);
    localparam int CNT_W   = HIST_AW + 1;
    localparam int LEN_W   = $clog2(MAX_LENGTH + 1);

    localparam logic [TOKEN_WIDTH-1:0] TOK_EOB  = TOKEN_WIDTH'(256);
    localparam logic [TOKEN_WIDTH-1:0] TOK_LEN0 = TOKEN_WIDTH'(257);
    localparam logic [TOKEN_WIDTH-1:0] TOK_LENN = TOKEN_WIDTH'(285);

    typedef enum logic [2:0] {
        ST_TOKEN,
        ST_LEN,
        ST_DIST,
        ST_COPY,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t               state;
    logic [HIST_AW-1:0]   wp;
    logic [CNT_W-1:0]     hist_count;
    logic [4:0]           idx_r;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     remain;
    logic [HIST_AW-1:0]   dist_r;
    logic [DATA_WIDTH-1:0] hist [HIST_SIZE];

    logic                   slot_free;
    logic                   tok_fire;
    logic                   is_lit;
    logic                   is_eob;
    logic                   is_code;
    logic                   len_ok;
    logic                   dist_ok;
    logic                   lit_fire;
    logic                   copy_fire;
    logic                   hist_we;
    logic [4:0]             code_idx;
    logic [TOKEN_WIDTH-1:0] base_lo;
    logic [TOKEN_WIDTH-1:0] base_hi;
    logic [HIST_AW-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0]  copy_byte;
    logic [DATA_WIDTH-1:0]  hist_wdata;

    function automatic logic [8:0] base_of(input logic [4:0] idx);
        case (idx)
            5'd0:    base_of = 9'd3;
            5'd1:    base_of = 9'd4;
            5'd2:    base_of = 9'd5;
            5'd3:    base_of = 9'd6;
            5'd4:    base_of = 9'd7;
            5'd5:    base_of = 9'd8;
            5'd6:    base_of = 9'd9;
            5'd7:    base_of = 9'd10;
            5'd8:    base_of = 9'd11;
            5'd9:    base_of = 9'd13;
            5'd10:   base_of = 9'd15;
            5'd11:   base_of = 9'd17;
            5'd12:   base_of = 9'd19;
            5'd13:   base_of = 9'd23;
            5'd14:   base_of = 9'd27;
            5'd15:   base_of = 9'd31;
            5'd16:   base_of = 9'd35;
            5'd17:   base_of = 9'd43;
            5'd18:   base_of = 9'd51;
            5'd19:   base_of = 9'd59;
            5'd20:   base_of = 9'd67;
            5'd21:   base_of = 9'd83;
            5'd22:   base_of = 9'd99;
            5'd23:   base_of = 9'd115;
            5'd24:   base_of = 9'd131;
            5'd25:   base_of = 9'd163;
            5'd26:   base_of = 9'd195;
            5'd27:   base_of = 9'd227;
            5'd28:   base_of = 9'd258;
            default: base_of = 9'd259;
        endcase
    endfunction

    always_comb begin
        slot_free = !out_valid || out_ready;
        tok_ready = 1'b0;
        case (state)
            ST_TOKEN:        tok_ready = slot_free;
            ST_LEN, ST_DIST: tok_ready = 1'b1;
            default:         tok_ready = 1'b0;
        endcase
    end

    assign tok_fire = tok_valid && tok_ready;
    assign is_lit   = tok_data < TOK_EOB;
    assign is_eob   = tok_data == TOK_EOB;
    assign is_code  = (tok_data >= TOK_LEN0) && (tok_data <= TOK_LENN);
    assign code_idx = 5'(tok_data - TOK_LEN0);

    assign base_lo = TOKEN_WIDTH'(base_of(idx_r));
    assign base_hi = TOKEN_WIDTH'(base_of(idx_r + 5'd1));
    assign len_ok  = (tok_data >= TOKEN_WIDTH'(3)) && (tok_data <= TOKEN_WIDTH'(MAX_LENGTH))
                  && (tok_data >= base_lo) && (tok_data < base_hi);
    assign dist_ok = (tok_data != '0) && (tok_data <= TOKEN_WIDTH'(HIST_SIZE))
                  && (tok_data <= TOKEN_WIDTH'(hist_count));

    // A distance of HIST_SIZE truncates to zero, so the copy reads the slot it is about to overwrite.
    assign rd_addr   = wp - dist_r;
    assign copy_byte = hist[rd_addr];

    assign lit_fire   = (state == ST_TOKEN) && tok_fire && is_lit;
    assign copy_fire  = (state == ST_COPY) && slot_free;
    assign hist_we    = !rst && !clr && (lit_fire || copy_fire);
    assign hist_wdata = copy_fire ? copy_byte : tok_data[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist[wp] <= hist_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= ST_TOKEN;
            wp         <= '0;
            hist_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            idx_r      <= '0;
            len_r      <= '0;
            remain     <= '0;
            dist_r     <= '0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Every byte entering history is also the next decoded output.
            if (hist_we) begin
                wp        <= wp + HIST_AW'(1);
                out_valid <= 1'b1;
                out_data  <= hist_wdata;
                if (hist_count != CNT_W'(HIST_SIZE)) begin
                    hist_count <= hist_count + CNT_W'(1);
                end
            end

            case (state)
                ST_TOKEN: begin
                    if (tok_fire) begin
                        if (is_eob) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (is_code) begin
                            idx_r <= code_idx;
                            state <= ST_LEN;
                        end else if (!is_lit) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_LEN: begin
                    if (tok_fire) begin
                        if (len_ok) begin
                            len_r <= LEN_W'(tok_data);
                            state <= ST_DIST;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_DIST: begin
                    if (tok_fire) begin
                        if (dist_ok) begin
                            dist_r <= HIST_AW'(tok_data);
                            remain <= len_r;
                            state  <= ST_COPY;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_COPY: begin
                    if (copy_fire) begin
                        remain <= remain - LEN_W'(1);
                        if (remain == LEN_W'(1)) begin
                            state <= ST_TOKEN;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed bench for lz77_decoder: a negedge monitor logs every output handshake; each task checks its own scenario.
module tb_lz77_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        tok_valid;
    logic [15:0] tok_data;
    logic        tok_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int tok_timeouts = 0;

    logic [7:0] got [$];
    time        got_t [$];

    always #5 clk = ~clk;

    lz77_decoder #(
        .DATA_WIDTH (8),
        .TOKEN_WIDTH(16),
        .HIST_SIZE  (64),
        .MAX_LENGTH (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .tok_valid(tok_valid),
        .tok_data (tok_data),
        .tok_ready(tok_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .done     (done),
        .error    (error)
    );

    always @(negedge clk) begin
        if (!rst && !clr && out_valid && out_ready) begin
            got.push_back(out_data);
            got_t.push_back($time);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got %0d bytes expected completion", got.size());
        $fatal(1);
    end

    task automatic do_reset();
        rst       = 1'b1;
        clr       = 1'b0;
        tok_valid = 1'b0;
        tok_data  = 16'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Holds the token until the edge that accepts it; returns 1 time unit after that edge.
    task automatic send_tok(input logic [15:0] v);
        bit acc = 1'b0;
        tok_valid = 1'b1;
        tok_data  = v;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (tok_ready) acc = 1'b1;
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end else begin
            tok_timeouts++;
        end
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 300 && got.size() < n; i++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL reset_tok_ready: got %b expected 1", tok_ready); end
    endtask

    task automatic test_literals();
        logic [7:0] lits [3];
        lits = '{8'h41, 8'h42, 8'h43};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_tok({8'h00, lits[i]});
            checks++;
            if (out_valid !== 1'b1 || out_data !== lits[i]) begin
                errors++;
                $display("FAIL literal_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, lits[i]);
            end
        end
        send_tok(16'd256);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL eob_done: got %b expected 1", done); end
        tok_data = 16'h0099;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || tok_ready !== 1'b0 || out_valid !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: got done=%b rdy=%b vld=%b err=%b expected 1 0 0 0", done, tok_ready, out_valid, error);
        end
        tok_valid = 1'b0;
        checks++; if (tok_timeouts !== 0) begin errors++; $display("FAIL literal_accept: got %0d timeouts expected 0", tok_timeouts); end
    endtask

    task automatic test_copy();
        logic [15:0] toks [6];
        logic [7:0]  exp_b [6];
        int base;
        toks  = '{16'h0061, 16'h0062, 16'h0063, 16'd257, 16'd3, 16'd3};
        exp_b = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
        do_reset();
        base = got.size();
        foreach (toks[i]) send_tok(toks[i]);
        tok_valid = 1'b0;
        wait_bytes(base + 6);
        checks++; if (got.size() != base + 6) begin errors++; $display("FAIL copy_count: got %0d expected %0d", got.size() - base, 6); end
        for (int i = 0; i < 6 && base + i < got.size(); i++) begin
            checks++;
            if (got[base + i] !== exp_b[i]) begin errors++; $display("FAIL copy_byte_%0d: got %h expected %h", i, got[base + i], exp_b[i]); end
        end
        if (got.size() >= base + 6) begin
            checks++;
            if (got_t[base + 5] - got_t[base + 3] != 20) begin
                errors++; $display("FAIL copy_rate: got %0t between bytes 3 and 5 expected 20", got_t[base + 5] - got_t[base + 3]);
            end
        end
        checks++;
        if (tok_ready !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL copy_back_to_token: got rdy=%b err=%b done=%b expected 1 0 0", tok_ready, error, done);
        end
    endtask

    // Length 10 uses code 264 (code 263 covers length 9 only); distance 1 replicates the seed byte.
    task automatic test_overlap();
        int base;
        do_reset();
        base = got.size();
        send_tok(16'h0055);
        send_tok(16'd264);
        send_tok(16'd10);
        send_tok(16'd1);
        tok_valid = 1'b0;
        wait_bytes(base + 11);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (got.size() != base + 11) begin errors++; $display("FAIL overlap_count: got %0d expected 11", got.size() - base); end
        for (int i = 0; i < 11 && base + i < got.size(); i++) begin
            checks++;
            if (got[base + i] !== 8'h55) begin errors++; $display("FAIL overlap_byte_%0d: got %h expected 55", i, got[base + i]); end
        end
        checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL overlap_ready: got %b expected 1", tok_ready); end
    endtask

    task automatic test_backpressure();
        logic [15:0] toks [6];
        logic [7:0]  exp_b [8];
        int ti = 0;
        int base;
        bit held = 1'b0;
        logic [7:0] held_data = 8'h00;
        toks  = '{16'h0011, 16'h0022, 16'h0033, 16'd259, 16'd5, 16'd3};
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
        do_reset();
        base = got.size();
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = cyc[0];
            if (ti < 6) begin
                tok_valid = 1'b1;
                tok_data  = toks[ti];
            end else begin
                tok_valid = 1'b0;
            end
            @(negedge clk);
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data) begin
                    errors++; $display("FAIL stall_hold_cyc%0d: got vld=%b data=%h expected 1 %h", cyc, out_valid, out_data, held_data);
                end
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (tok_valid && tok_ready) ti++;
            @(posedge clk);
            #1;
        end
        tok_valid = 1'b0;
        out_ready = 1'b1;
        wait_bytes(base + 8);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ti != 6) begin errors++; $display("FAIL stall_tokens: got %0d accepted expected 6", ti); end
        checks++; if (got.size() != base + 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", got.size() - base); end
        for (int i = 0; i < 8 && base + i < got.size(); i++) begin
            checks++;
            if (got[base + i] !== exp_b[i]) begin errors++; $display("FAIL stall_byte_%0d: got %h expected %h", i, got[base + i], exp_b[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] seqs [5][5];
        int n_tok [5];
        seqs  = '{'{16'h0061, 16'd257, 16'd4, 16'd0, 16'd0},
                  '{16'h0001, 16'h0002, 16'd257, 16'd3, 16'd5},
                  '{16'h0055, 16'd263, 16'd10, 16'd0, 16'd0},
                  '{16'd286, 16'd0, 16'd0, 16'd0, 16'd0},
                  '{16'h0001, 16'd257, 16'd3, 16'd0, 16'd0}};
        n_tok = '{3, 5, 3, 1, 4};
        for (int c = 0; c < 5; c++) begin
            do_reset();
            for (int t = 0; t < n_tok[c] - 1; t++) send_tok(seqs[c][t]);
            checks++; if (error !== 1'b0) begin errors++; $display("FAIL illegal_pre_%0d: got error=%b expected 0", c, error); end
            send_tok(seqs[c][n_tok[c] - 1]);
            tok_data = 16'd1;
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (error !== 1'b1 || tok_ready !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL illegal_%0d: got err=%b rdy=%b done=%b expected 1 0 0", c, error, tok_ready, done);
            end
            tok_valid = 1'b0;
        end
        checks++; if (tok_timeouts !== 0) begin errors++; $display("FAIL illegal_accept: got %0d timeouts expected 0", tok_timeouts); end
    endtask

    task automatic test_wrap();
        int base;
        logic [7:0] exp_v;
        do_reset();
        base = got.size();
        for (int k = 0; k < 70; k++) send_tok(16'(k + 16));
        send_tok(16'd257);
        send_tok(16'd3);
        send_tok(16'd64);
        tok_valid = 1'b0;
        wait_bytes(base + 73);
        checks++; if (got.size() != base + 73) begin errors++; $display("FAIL wrap_count: got %0d expected 73", got.size() - base); end
        for (int i = 0; i < 73 && base + i < got.size(); i++) begin
            exp_v = (i < 70) ? 8'(i + 16) : 8'(i - 64 + 16);
            checks++;
            if (got[base + i] !== exp_v) begin errors++; $display("FAIL wrap_byte_%0d: got %h expected %h", i, got[base + i], exp_v); end
        end
    endtask

    task automatic test_clr_rst_abort();
        do_reset();
        send_tok(16'h0061);
        send_tok(16'h0062);
        send_tok(16'h0063);
        send_tok(16'd260);
        send_tok(16'd6);
        send_tok(16'd3);
        tok_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin errors++; $display("FAIL clr_pre_copy: got vld=%b data=%h expected 1 61", out_valid, out_data); end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || tok_ready !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL clr_mid_copy: got vld=%b rdy=%b err=%b done=%b expected 0 1 0 0", out_valid, tok_ready, error, done);
        end
        // clr wins over a literal presented on the same edge.
        tok_valid = 1'b1;
        tok_data  = 16'h0077;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        tok_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_priority: got vld=%b expected 0", out_valid); end
        send_tok(16'h005A);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL clr_restart: got vld=%b data=%h expected 1 5a", out_valid, out_data); end
        // Only one byte written since clr, so distance 2 must be rejected.
        send_tok(16'd257);
        send_tok(16'd3);
        send_tok(16'd2);
        tok_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL clr_hist_count: got error=%b expected 1", error); end

        do_reset();
        send_tok(16'h0061);
        send_tok(16'd259);
        send_tok(16'd5);
        send_tok(16'd1);
        tok_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || tok_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_copy: got vld=%b data=%h rdy=%b expected 0 00 1", out_valid, out_data, tok_ready);
        end
    endtask

    initial begin
        test_reset();
        test_literals();
        test_copy();
        test_overlap();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_clr_rst_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
